// File: rtl/ctrl_result_writeback.sv
// Captures one tile of deskewed result rows, applies optional ReLU and writes
// each row to the results SRAM one cycle after it arrives.
module ctrl_result_writeback #(
  parameter int MATRIX_SIZE    = 32,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int ADDRESSSIZE    = 10
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic                                  relu_en,
  input  logic                                  row_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_data,
  output logic                                  sram_we,
  output logic [ADDRESSSIZE-1:0]                sram_addr,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_wdata,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(MATRIX_SIZE):0]          row_count,
  output logic                                  stray_err,
  output logic [1:0]                            fsm_state
);

  localparam int RW = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int CW = $clog2(MATRIX_SIZE) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  logic [ADDRESSSIZE-1:0] base_q;
  logic                   relu_q;
  logic                   tile_full;
  logic                   capture;
  logic [ADDRESSSIZE-1:0] row_addr;
  logic [RW-1:0]          row_relu;

  // row_valid is a one-way strobe with no ready: every row_valid cycle in
  // ARMED, or in WRITE before the tile is full, is consumed as the next row.
  assign tile_full = (row_count == CW'(MATRIX_SIZE));
  assign capture   = row_valid && ((state == ARMED) || ((state == WRITE) && !tile_full));
  assign row_addr  = base_q + ADDRESSSIZE'(row_count);

  always_comb begin
    row_relu = row_data;
    if (relu_q) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        if (row_data[i*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1]) begin
          row_relu[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      base_q     <= '0;
      relu_q     <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      row_count  <= '0;
      stray_err  <= 1'b0;
    end else begin
      sram_we <= capture;
      if (capture) begin
        sram_addr  <= row_addr;
        sram_wdata <= row_relu;
        row_count  <= row_count + CW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ARMED;
            base_q    <= base_addr;
            relu_q    <= relu_en;
            row_count <= '0;
            stray_err <= 1'b0;
          end else if (row_valid) begin
            stray_err <= 1'b1;
          end
        end
        ARMED: begin
          if (row_valid) state <= WRITE;
        end
        WRITE: begin
          // Tile full means this is the final write cycle; any row now is stray.
          if (tile_full) begin
            state <= DONE;
            if (row_valid) stray_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          if (row_valid) stray_err <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = (state == ARMED) || (state == WRITE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: doc/ctrl_result_writeback.md
CTRL_RESULT_WRITEBACK -- requirements
Module: ctrl_result_writeback

Interface
REQ-001 The block SHALL have parameter MATRIX_SIZE, default 32, meaning lanes per result row and rows per tile.
REQ-002 The block SHALL have parameter PARTIAL_SUM_BW, default 24, meaning signed bits per lane.
REQ-003 The block SHALL have parameter ADDRESSSIZE, default 10, meaning width of the results-SRAM address.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port start  input  1  arm request for one tile capture.
REQ-007 The block SHALL have port base_addr  input  ADDRESSSIZE  first SRAM row address of the tile, sampled with start.
REQ-008 The block SHALL have port relu_en  input  1  clamp negative lanes to zero, sampled with start.
REQ-009 The block SHALL have port row_valid  input  1  row_data carries one deskewed, lane-ordered result row this cycle.
REQ-010 The block SHALL have port row_data  input  PARTIAL_SUM_BW*MATRIX_SIZE  result row; lane i at bits [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], two's complement.
REQ-011 The block SHALL have port sram_we  output  1  results-SRAM write enable.
REQ-012 The block SHALL have port sram_addr  output  ADDRESSSIZE  results-SRAM address.
REQ-013 The block SHALL have port sram_wdata  output  PARTIAL_SUM_BW*MATRIX_SIZE  results-SRAM write data.
REQ-014 The block SHALL have port busy  output  1  high in ARMED and WRITE.
REQ-015 The block SHALL have port done  output  1  one-cycle pulse when a tile is fully written.
REQ-016 The block SHALL have port row_count  output  $clog2(MATRIX_SIZE)+1  rows written in the current or last tile.
REQ-017 The block SHALL have port stray_err  output  1  sticky flag: row_valid seen while not capturing.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, WRITE, DONE.
REQ-019 IDLE -> ARMED on start=1: latch base_addr and relu_en, clear row_count, clear stray_err.
REQ-020 ARMED SHALL go to WRITE on the first row_valid=1 cycle, and that row SHALL be captured as row 0.
REQ-021 In ARMED/WRITE each row_valid=1 cycle SHALL capture one row; gaps (row_valid=0) SHALL be allowed with no row lost.
REQ-022 A row captured at cycle t SHALL appear at cycle t+1 with sram_we=1, sram_addr=(base_addr+k) mod 2^ADDRESSSIZE for row index k, and sram_wdata = the registered row.
REQ-023 With relu_en latched =1, each lane with sign bit 1 SHALL be written as 0; other lanes pass unchanged, with no width change.
REQ-024 row_count SHALL increment in the same cycle as the corresponding sram_we.
REQ-025 After row MATRIX_SIZE-1 is captured, the FSM SHALL enter DONE. row_valid in that final write cycle SHALL be ignored and SHALL set stray_err.
REQ-026 DONE SHALL last exactly one cycle with done=1, which is the cycle after the last sram_we, then go to IDLE.
REQ-027 start in ARMED, WRITE or DONE SHALL be ignored.
REQ-028 row_valid in IDLE or DONE SHALL not write and SHALL set stray_err, which holds until the next accepted start.
REQ-029 Simultaneous start and row_valid in IDLE SHALL arm only; that row is not captured and SHALL set stray_err, which is then cleared by the start.
REQ-030 When relu_en=0, sram_wdata SHALL be bit-exact with the row_data.
REQ-031 sram_we SHALL never be high for more than MATRIX_SIZE cycles per tile.

Reset
REQ-032 rstn=0 SHALL asynchronously force IDLE with sram_we=0, sram_addr=0, sram_wdata=0, busy=0, done=0, row_count=0, stray_err=0, including mid-tile.
REQ-033 After rstn deassertion, the block SHALL require a new start before any write; rows of an aborted tile SHALL not resume.

Verification
REQ-034 The bench SHALL cover: start with base_addr=0x010, then 32 consecutive row_valid rows, lane0 = row index -> sram_we at addresses 0x010..0x02F, row_count=32, and done pulses exactly 1 cycle after the last write.
REQ-035 The bench SHALL cover: base_addr=0x3F0 with 32 rows -> addresses 0x3F0..0x3FF then 0x000..0x00F (wrap), and done=1.
REQ-036 The bench SHALL cover: relu_en=1, lane values -5, 0, 7, 0x800000 -> written as 0, 0, 7, 0; with relu_en=0 the same values are written unchanged.
REQ-037 The bench SHALL cover: row_valid asserted every other cycle -> 32 writes with no loss; a second start during WRITE is ignored; busy stays 1 until done.
REQ-038 The bench SHALL cover: row_valid in IDLE -> no sram_we and stray_err=1; the next start clears it.
REQ-039 The bench SHALL cover: rstn=0 pulse after 10 rows -> all outputs 0 immediately; then a fresh start gives 32 writes from the new base_addr.
